// File: rtl/ofifo_drain.sv
// Output-FIFO drain controller: pops num_rows psum rows and writes them to consecutive psum SRAM addresses.
// Build macro OFIFO_DRAIN_RELU_EN clamps negative lanes to zero on the way into the SRAM data register.
module ofifo_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw-1:0]       num_rows,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  output logic                     busy,
  output logic                     done,
  output logic [addr_bw-1:0]       row_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [addr_bw-1:0]       r_base;
  logic [addr_bw-1:0]       r_num;
  logic [addr_bw-1:0]       r_issued;
  logic [addr_bw-1:0]       r_written;
  logic [addr_bw-1:0]       r_row_cnt;
  logic [addr_bw-1:0]       r_addr_p1;
  logic [col*psum_bw-1:0]   r_d_p1;
  logic                     r_cen_p1;
  logic                     r_rd_p0;
  logic                     w_rd;
  logic [col*psum_bw-1:0]   w_wdata;

`ifdef OFIFO_DRAIN_RELU_EN
  function automatic logic [psum_bw-1:0] relu_lane(input logic signed [psum_bw-1:0] x);
    return x[psum_bw-1] ? '0 : x;
  endfunction
`endif

  always_comb begin
    w_wdata = ofifo_out;
`ifdef OFIFO_DRAIN_RELU_EN
    for (int i = 0; i < col; i++) begin
      w_wdata[i*psum_bw +: psum_bw] = relu_lane(ofifo_out[i*psum_bw +: psum_bw]);
    end
`endif
  end

  // Pop request: never beyond num_rows, never while reset is asserted.
  assign w_rd = reset && (r_state == S_RUN) && (r_issued < r_num) && ofifo_valid;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = (num_rows == '0) ? S_DONE : S_RUN;
      S_RUN:   if (!r_cen_p1 && (r_written == r_num)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_num     <= '0;
      r_issued  <= '0;
      r_written <= '0;
      r_row_cnt <= '0;
      r_rd_p0   <= 1'b0;
      r_cen_p1  <= 1'b1;
      r_addr_p1 <= '0;
      r_d_p1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_base    <= base_addr;
        r_num     <= num_rows;
        r_issued  <= '0;
        r_written <= '0;
        r_row_cnt <= '0;
      end
      if (w_rd) r_issued <= r_issued + addr_bw'(1);
      // p0: pop issued last cycle, FIFO data valid now
      r_rd_p0 <= w_rd;
      // p1: capture FIFO data into the SRAM write register
      r_cen_p1 <= ~r_rd_p0;
      if (r_rd_p0) begin
        r_d_p1    <= w_wdata;
        r_addr_p1 <= r_base + r_written;
        r_written <= r_written + addr_bw'(1);
        r_row_cnt <= r_row_cnt + addr_bw'(1);
      end
    end
  end

  assign ofifo_rd  = w_rd;
  assign sram_cen  = r_cen_p1;
  assign sram_wen  = r_cen_p1;
  assign sram_addr = r_addr_p1;
  assign sram_d    = r_d_p1;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign row_cnt   = r_row_cnt;

endmodule

// File: doc/ofifo_drain.md
# ofifo_drain

Read-side controller for the output FIFO of the systolic array. On a start pulse it pops a programmed number of psum rows (one `col`-wide word per pop) from the output FIFO whenever the FIFO reports all columns valid, and writes each row into consecutive addresses of the psum SRAM. It sits between the output FIFO and the psum SRAM and is sequenced by the core controller through `start`, `busy` and `done`.

## Interface
Parameters:
- `col`, 8, number of array columns (lanes per row)
- `psum_bw`, 16, bits per psum lane (two's complement)
- `addr_bw`, 11, psum SRAM address width

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `start`  in  1  one-cycle request to begin a drain; ignored while `busy`
- `base_addr`  in  addr_bw  first SRAM address; sampled on accepted `start`
- `num_rows`  in  addr_bw  rows to drain; sampled on accepted `start`
- `ofifo_valid`  in  1  output FIFO has one full row available (all columns non-empty)
- `ofifo_out`  in  col*psum_bw  output FIFO read data, valid the cycle after a pop
- `ofifo_rd`  out  1  pop one row from output FIFO
- `sram_cen`  out  1  psum SRAM chip enable, active-low
- `sram_wen`  out  1  psum SRAM write enable, active-low
- `sram_addr`  out  addr_bw  psum SRAM address
- `sram_d`  out  col*psum_bw  psum SRAM write data, lane i at bits [(i+1)*psum_bw-1 : i*psum_bw]
- `busy`  out  1  drain in progress
- `done`  out  1  one-cycle pulse on completion
- `row_cnt`  out  addr_bw  rows written in current/last drain

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 latches `base_addr`, `num_rows`; clears issue count, write count, `row_cnt`; goes RUN (or DONE directly if `num_rows`=0).
- RUN: `ofifo_rd` = (`issued` < `num_rows`) && `ofifo_valid`, combinational from registered state; each pop increments `issued`.
- Pop pipeline: stage 1 flag `rd_q` <= `ofifo_rd`; when `rd_q`=1, register `ofifo_out` into `sram_d`, `sram_addr` <= base + `written` (modulo 2^addr_bw), `sram_cen`=`sram_wen`=0 for that one cycle; `written`, `row_cnt` increment.
- RUN -> DONE when the write of row `num_rows`-1 has been issued to the SRAM. DONE: `done`=1 one cycle, then IDLE.
- `busy`=1 in RUN only; `start` during RUN/DONE ignored, latched parameters unchanged.
- `ofifo_valid` dropping mid-drain: pops stop, in-flight pop still written; resumes when valid returns. Write gaps are legal.
- Never pops beyond `num_rows`, even if `ofifo_valid` stays high.
- `reset`=0 at any edge: state IDLE, all counters 0, in-flight pop discarded (no SRAM write), outputs to reset values. `ofifo_rd` forced 0 while `reset`=0.

## Timing
- Reset values: `ofifo_rd` 0, `sram_cen` 1, `sram_wen` 1, `sram_addr` 0, `sram_d` 0, `busy` 0, `done` 0, `row_cnt` 0.
- `start` sampled at edge k; RUN and `busy` from cycle k+1; earliest pop in cycle k+1.
- Pop in cycle t -> SRAM write strobes in cycle t+2. Throughput 1 row/cycle with `ofifo_valid` continuously high.
- Last write in cycle w -> `done` and `busy`=0 in cycle w+1; new `start` accepted from cycle w+2.
- `num_rows`=0: `done` in cycle k+1, `busy` never asserted, no pops, no writes.
- Address wrap: base 2046, 4 rows -> addresses 2046, 2047, 0, 1 (addr_bw=11).

## Configuration
- `OFIFO_DRAIN_RELU_EN` defined: each lane is treated as signed; a negative lane is written as 0, others unchanged, applied before the `sram_d` register (no added latency).
- Undefined: lanes written bit-exact as popped.

## Test plan
- Reset mid-drain: `num_rows`=8, drive `reset`=0 after 3 pops -> next cycle all outputs at reset values, no further `sram_cen`=0, `row_cnt`=0.
- Streaming: `ofifo_valid`=1 constantly, base 0x010, `num_rows`=4 -> `ofifo_rd` high 4 consecutive cycles, writes to 0x010..0x013 in 4 consecutive cycles two cycles later, `done` one cycle after last write, `row_cnt`=4.
- Stalling: `ofifo_valid` toggled 1,0,0,1,1,0,1, `num_rows`=4 -> exactly 4 pops, each written 2 cycles after its pop, data order preserved.
- Over-supply and wrap: `ofifo_valid`=1 for 20 cycles, base 2046, `num_rows`=4 -> exactly 4 pops, addresses 2046, 2047, 0, 1; `start` pulsed during RUN ignored.
- Zero rows: `num_rows`=0 -> `done` at k+1, `ofifo_rd` and `sram_cen` never active.
- Lane data: row with lane0=0x8001, lane1=0x7FFF -> with `OFIFO_DRAIN_RELU_EN` written 0x0000, 0x7FFF; without, 0x8001, 0x7FFF.
